// File: rtl/shift_counter_pkg.sv
// Shared types and pure helpers for the bounded-run Johnson/ring counter.
package shift_counter_pkg;

    // Widest counter the helper functions handle; callers zero-extend into this width.
    localparam int unsigned MAX_W = 32;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One shift step of a w-bit counter held in the low bits of q (upper bits zero).
    // Johnson feeds back the inverted outgoing bit, ring feeds it back unchanged.
    function automatic logic [MAX_W-1:0] next_value(
        input logic [MAX_W-1:0] q,
        input int unsigned      w,
        input logic             mode,
        input logic             dir
    );
        logic [MAX_W-1:0] res;
        logic             out_bit;
        res = '0;
        if (dir == DIR_LEFT) begin
            out_bit = q[w-1];
            res     = q << 1;
            if (w < MAX_W) begin
                res[w] = 1'b0;
            end
            res[0] = (mode == MODE_RING) ? out_bit : ~out_bit;
        end else begin
            out_bit  = q[0];
            res      = q >> 1;
            res[w-1] = (mode == MODE_RING) ? out_bit : ~out_bit;
        end
        return res;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/shift_counter_ctrl_core.sv
// WIDTH-bit counter register: parallel load or one Johnson/ring shift per enabled edge.
module shift_core
    import shift_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_shift,
    input  logic             i_mode,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [MAX_W-1:0] w_q_ext;
    logic [MAX_W-1:0] w_next_ext;
    logic [WIDTH-1:0] w_next;
    logic             w_unused_hi;

    // Zero-extend the register into the helper width and apply one shift step.
    always_comb begin
        w_q_ext              = '0;
        w_q_ext[WIDTH-1:0]   = r_q;
        w_next_ext           = next_value(w_q_ext, WIDTH, i_mode, i_dir);
        w_next               = w_next_ext[WIDTH-1:0];
    end

    // Upper helper bits are always zero; folded here so they are visibly consumed.
    assign w_unused_hi = ^w_next_ext;

    // Counter register: reset clears, load wins over shift, otherwise hold.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_shift) begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_counter_ctrl.sv
// Run controller: accepts a start command, performs exactly `steps` shifts with
// pause/abort handling, then pulses done. Ring starts with a bad seed pulse err.
module shift_counter_ctrl
    import shift_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             mode,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [WIDTH-1:0] seed,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] Count_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_mode;
    logic             r_dir;
    logic [CNT_W-1:0] r_remaining;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [MAX_W-1:0] w_seed_ext;
    logic             w_seed_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_shift;
    logic [WIDTH-1:0] w_load_val;

    // Seed validation, only meaningful for ring-mode starts.
    always_comb begin
        w_seed_ext            = '0;
        w_seed_ext[WIDTH-1:0] = seed;
        w_seed_ok             = is_onehot(w_seed_ext);
    end

    // Johnson runs always begin from zero; ring runs begin from the seed.
    assign w_load_val = (mode == MODE_RING) ? seed : '0;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-edge control decode; RUN priority is abort > pause > shift.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((mode == MODE_RING) && !w_seed_ok) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = (steps == '0) ? ST_DONE : ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!pause) begin
                    w_shift = 1'b1;
                    if (r_remaining == CNT_ONE) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command capture, remaining-step countdown and registered status outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mode      <= MODE_JOHNSON;
            r_dir       <= DIR_LEFT;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode      <= mode;
                r_dir       <= dir;
                r_remaining <= steps;
            end else if (w_shift) begin
                r_remaining <= r_remaining - CNT_ONE;
            end
            r_busy <= (w_state_nxt == ST_RUN);
            r_done <= (w_state_nxt == ST_DONE);
            r_err  <= w_reject;
        end
    end

    shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_shift    (w_shift),
        .i_mode     (r_mode),
        .i_dir      (r_dir),
        .o_q        (Count_out)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_shift_counter_ctrl.sv
// Directed bench for shift_counter_ctrl with hand-computed expected sequences.
module tb_shift_counter_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       mode  = 1'b0;
    logic       dir   = 1'b0;
    logic [7:0] steps = 8'd0;
    logic [3:0] seed  = 4'd0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] Count_out;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [3:0] exp_jl [0:8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] exp_rr [0:5] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

    shift_counter_ctrl #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .start     (start),
        .mode      (mode),
        .dir       (dir),
        .steps     (steps),
        .seed      (seed),
        .pause     (pause),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .Count_out (Count_out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_status(input string tag, input logic b, input logic d,
                                input logic e, input logic [3:0] q);
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"},  32'(err),  32'(e));
        check({tag, "_q"},    32'(Count_out), 32'(q));
    endtask

    initial begin
        // Reset state
        tick();
        check_status("rst", 1'b0, 1'b0, 1'b0, 4'b0000);
        Reset = 1'b0;
        tick();
        check_status("idle", 1'b0, 1'b0, 1'b0, 4'b0000);

        // Johnson left, 8 steps
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd8;
        tick();
        start = 1'b0;
        check_status("jl0", 1'b1, 1'b0, 1'b0, exp_jl[0]);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check_status($sformatf("jl%0d", k), 1'b1, 1'b0, 1'b0, exp_jl[k]);
            else       check_status($sformatf("jl%0d", k), 1'b0, 1'b1, 1'b0, exp_jl[k]);
        end
        tick();
        check_status("jl_hold", 1'b0, 1'b0, 1'b0, 4'b0000);

        // Ring right from 0001, 5 steps
        start = 1'b1; mode = 1'b1; dir = 1'b1; steps = 8'd5; seed = 4'b0001;
        tick();
        start = 1'b0;
        check_status("rr0", 1'b1, 1'b0, 1'b0, exp_rr[0]);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5) check_status($sformatf("rr%0d", k), 1'b1, 1'b0, 1'b0, exp_rr[k]);
            else       check_status($sformatf("rr%0d", k), 1'b0, 1'b1, 1'b0, exp_rr[k]);
        end
        tick();
        check_status("rr_hold", 1'b0, 1'b0, 1'b0, 4'b1000);

        // Rejected ring starts: multi-bit and zero seeds
        start = 1'b1; mode = 1'b1; seed = 4'b0011; steps = 8'd3;
        tick();
        start = 1'b0;
        check_status("err_multi", 1'b0, 1'b0, 1'b1, 4'b1000);
        tick();
        check_status("err_multi_end", 1'b0, 1'b0, 1'b0, 4'b1000);
        start = 1'b1; seed = 4'b0000;
        tick();
        start = 1'b0;
        check_status("err_zero", 1'b0, 1'b0, 1'b1, 4'b1000);
        tick();
        check_status("err_zero_end", 1'b0, 1'b0, 1'b0, 4'b1000);

        // Ring left from 0100, 3 steps: 1000, 0001, 0010
        start = 1'b1; mode = 1'b1; dir = 1'b0; seed = 4'b0100; steps = 8'd3;
        tick();
        start = 1'b0;
        check("rl0_q", 32'(Count_out), 32'(4'b0100));
        tick(); check("rl1_q", 32'(Count_out), 32'(4'b1000));
        tick(); check("rl2_q", 32'(Count_out), 32'(4'b0001));
        tick(); check_status("rl3", 1'b0, 1'b1, 1'b0, 4'b0010);
        tick();

        // Johnson right, 2 steps: 1000, 1100
        start = 1'b1; mode = 1'b0; dir = 1'b1; steps = 8'd2;
        tick();
        start = 1'b0;
        check("jr0_q", 32'(Count_out), 32'(4'b0000));
        tick(); check("jr1_q", 32'(Count_out), 32'(4'b1000));
        tick(); check_status("jr2", 1'b0, 1'b1, 1'b0, 4'b1100);
        tick();

        // Johnson left, 4 steps, pause for 2 cycles after the 2nd shift
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd4;
        tick();
        start = 1'b0;
        tick(); check("p1_q", 32'(Count_out), 32'(4'b0001));
        tick(); check("p2_q", 32'(Count_out), 32'(4'b0011));
        pause = 1'b1;
        tick(); check_status("p_hold1", 1'b1, 1'b0, 1'b0, 4'b0011);
        tick(); check_status("p_hold2", 1'b1, 1'b0, 1'b0, 4'b0011);
        pause = 1'b0;
        tick(); check_status("p3", 1'b1, 1'b0, 1'b0, 4'b0111);
        tick(); check_status("p4", 1'b0, 1'b1, 1'b0, 4'b1111);
        tick(); check_status("p_after", 1'b0, 1'b0, 1'b0, 4'b1111);

        // Johnson left, 6 steps, abort after the 3rd shift
        start = 1'b1; steps = 8'd6;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("a3_q", 32'(Count_out), 32'(4'b0111));
        abort = 1'b1;
        tick();
        check_status("abort", 1'b0, 1'b0, 1'b0, 4'b0111);
        abort = 1'b0;
        tick();
        check_status("abort_idle", 1'b0, 1'b0, 1'b0, 4'b0111);

        // Start held high through RUN and DONE with a different command is ignored
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd3;
        tick();
        mode = 1'b1; seed = 4'b1000; steps = 8'd7;
        tick(); check("ign1_q", 32'(Count_out), 32'(4'b0001));
        tick(); check("ign2_q", 32'(Count_out), 32'(4'b0011));
        tick(); check_status("ign3", 1'b0, 1'b1, 1'b0, 4'b0111);
        tick(); check_status("ign_done", 1'b0, 1'b0, 1'b0, 4'b0111);
        start = 1'b0;
        tick();

        // Zero-step starts complete immediately
        start = 1'b1; mode = 1'b0; steps = 8'd0;
        tick();
        start = 1'b0;
        check_status("z_j", 1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        check_status("z_j_end", 1'b0, 1'b0, 1'b0, 4'b0000);
        start = 1'b1; mode = 1'b1; seed = 4'b0100;
        tick();
        start = 1'b0;
        check_status("z_r", 1'b0, 1'b1, 1'b0, 4'b0100);
        tick();

        // Reset mid-run with pause and start active
        start = 1'b1; mode = 1'b0; dir = 1'b0; steps = 8'd8;
        tick();
        start = 1'b0;
        tick(); tick();
        check("r2_q", 32'(Count_out), 32'(4'b0011));
        Reset = 1'b1; pause = 1'b1; start = 1'b1;
        tick();
        check_status("mid_rst", 1'b0, 1'b0, 1'b0, 4'b0000);
        Reset = 1'b0; pause = 1'b0; start = 1'b0;
        tick();
        check_status("post_rst", 1'b0, 1'b0, 1'b0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
